iic_arbiter: RTL
================

// Module: iic_arbiter
// PURPOSE
//   Round-robin arbiter that shares a single iic_master between NUM_REQ independent
//   requesters (init sequencer, runtime register writer, status poller, ...).
//   Accepts one complete I2C register transaction per grant and drives the master's
//   send_en/send_busy handshake. Returns read data and a completion/error pulse to the owner.
//   Sits between the requesters and iic_master; only one transaction is in flight.
// PARAMETERS
//   NUM_REQ  4     number of requesters (2..8)
//   ADDR_W   16    slave address width, matches iic_master slave_addr
//   REG_W    16    register address width (8 or 16, = 8+IIC_SLAVE_REG_EX*8)
//   TIMEOUT  1023  cycles to wait for m_send_busy to rise after send_en, before flagging error
// PORTS
//   clk             in   1              system clock
//   rst_n           in   1              asynchronous active-low reset
//   req_valid       in   NUM_REQ        requester i has a transaction pending (level)
//   req_rw          in   NUM_REQ        per-requester 0=write 1=read
//   req_slave_addr  in   NUM_REQ*ADDR_W  packed slave address, requester i at [i*ADDR_W +: ADDR_W]
//   req_reg_addr    in   NUM_REQ*REG_W   packed register address
//   req_wdata       in   NUM_REQ*8       packed write data
//   req_ready       out  NUM_REQ        1-cycle accept pulse, one-hot; fields sampled that cycle
//   rsp_valid       out  NUM_REQ        1-cycle completion pulse to the owning requester
//   rsp_rdata       out  8              read data, valid with rsp_valid
//   rsp_err         out  1              timeout flag, valid with rsp_valid
//   m_slave_addr    out  ADDR_W         to iic_master slave_addr
//   m_send_rw       out  1              to iic_master send_rw
//   m_reg_addr      out  REG_W          to iic_master reg_addr
//   m_send_data     out  8              to iic_master send_data
//   m_send_en       out  1              to iic_master send_en
//   m_recv_data     in   8              from iic_master recv_data
//   m_send_busy     in   1              from iic_master send_busy
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority).
//   Reset mid-transaction aborts silently; no rsp_valid is issued for the lost transaction.
//   FSM states: IDLE, START, RUN, DONE.
//   IDLE: when |req_valid and !m_send_busy, pick the first valid index scanning
//     last_grant+1, +2, ... (mod NUM_REQ). Latch rw/slave/reg/wdata into the m_* registers.
//     Pulse req_ready[g]=1 for this one cycle, store g, clear timer, go to START.
//     If m_send_busy=1, no grant is made.
//   START: m_send_en=1 (held). When m_send_busy=1: m_send_en=0, go to RUN.
//     If the timer reaches TIMEOUT first: m_send_en=0, set err=1, go to DONE.
//   RUN: wait for m_send_busy=0, then capture m_recv_data into rsp_rdata and go to DONE.
//   DONE: rsp_valid[g]=1 for exactly one cycle, rsp_err=err, last_grant<=g, go to IDLE.
//     rsp_rdata/rsp_err hold their value until the next DONE.
//   m_* address/data outputs stay stable from the grant until the next grant.
//   Latency: req_ready comes 1 cycle after req_valid when the arbiter is idle.
//     rsp_valid comes 1 cycle after m_send_busy falls.
//   Minimum spacing between grants is 4 cycles (IDLE, START, RUN, DONE).
//   Requester rule: deassert req_valid (or present the next transaction) in the cycle
//     after req_ready. Changes to req_* fields outside the accept cycle are ignored.
//   A requester that drops req_valid before it is granted simply loses its turn; this is
//     not an error.
//   Fairness: any continuously-valid requester is granted within NUM_REQ grants.
//   The timer is ceil(log2(TIMEOUT+1)) bits wide and saturates; it counts only in START.
// TESTING
//   1 Single write: req_valid[0], reg 16'h3A2B, data 8'h55 -> req_ready[0] 1 cycle later;
//     m_send_en held until busy; rsp_valid[0] with rsp_err=0.
//   2 All 4 valid continuously -> grant order 0,1,2,3,0; never two req_ready bits in one cycle.
//   3 Read on requester 2, model returns 8'hC3 -> rsp_valid[2], rsp_rdata=8'hC3.
//   4 Model never raises busy -> after TIMEOUT=1023 cycles in START, rsp_valid=1, rsp_err=1,
//     m_send_en=0; the next request is served normally.
//   5 m_send_busy=1 at the moment req_valid rises -> no req_ready until busy drops.
//   6 rst_n pulsed low during RUN -> all outputs 0 immediately; after release requester 0
//     wins over 3 when both are valid.

Source files
------------

// File: rtl/iic_arbiter.sv
// rtl/iic_arbiter.sv - round-robin arbiter sharing one iic_master among NUM_REQ requesters
// One transaction in flight; registered grant/response pulses, timeout on missing busy.
module iic_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_slave_addr,
  input  logic [NUM_REQ*REG_W-1:0]  req_reg_addr,
  input  logic [NUM_REQ*8-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [7:0]                rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         m_slave_addr,
  output logic                      m_send_rw,
  output logic [REG_W-1:0]          m_reg_addr,
  output logic [7:0]                m_send_data,
  output logic                      m_send_en,
  input  logic [7:0]                m_recv_data,
  input  logic                      m_send_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        last_q, last_d, gnt_q, gnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d, rvalid_q, rvalid_d;
  logic [7:0]           rdata_q, rdata_d, wd_q, wd_d;
  logic                 err_q, err_d, rw_q, rw_d, en_q, en_d;
  logic [ADDR_W-1:0]    sa_q, sa_d;
  logic [REG_W-1:0]     ra_q, ra_d;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Scan starts just after the last owner, so the last owner has lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_found && req_valid[rr_idx(last_q, i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx(last_q, i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    timer_d  = timer_q;
    ready_d  = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    sa_d     = sa_q;
    rw_d     = rw_q;
    ra_d     = ra_q;
    wd_d     = wd_q;
    en_d     = en_q;
    case (state_q)
      IDLE: begin
        if (pick_found && !m_send_busy) begin
          ready_d[pick_idx] = 1'b1;
          gnt_d   = pick_idx;
          sa_d    = req_slave_addr[pick_idx*ADDR_W +: ADDR_W];
          ra_d    = req_reg_addr[pick_idx*REG_W +: REG_W];
          wd_d    = req_wdata[pick_idx*8 +: 8];
          rw_d    = req_rw[pick_idx];
          timer_d = '0;
          en_d    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (m_send_busy) begin
          en_d    = 1'b0;
          state_d = RUN;
        end else if (32'(timer_q) + 1 >= TIMEOUT) begin
          en_d            = 1'b0;
          rvalid_d[gnt_q] = 1'b1;
          err_d           = 1'b1;
          rdata_d         = 8'h00;
          state_d         = DONE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      RUN: begin
        if (!m_send_busy) begin
          rvalid_d[gnt_q] = 1'b1;
          rdata_d         = m_recv_data;
          err_d           = 1'b0;
          state_d         = DONE;
        end
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= IW'(NUM_REQ - 1);
      gnt_q    <= '0;
      timer_q  <= '0;
      ready_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sa_q     <= '0;
      rw_q     <= 1'b0;
      ra_q     <= '0;
      wd_q     <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      timer_q  <= timer_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      sa_q     <= sa_d;
      rw_q     <= rw_d;
      ra_q     <= ra_d;
      wd_q     <= wd_d;
      en_q     <= en_d;
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rvalid_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign m_slave_addr = sa_q;
  assign m_send_rw    = rw_q;
  assign m_reg_addr   = ra_q;
  assign m_send_data  = wd_q;
  assign m_send_en    = en_q;

endmodule
